// File: rtl/m_stage_mem_ctrl_if.sv
// m_stage_mem_ctrl_if: valid/ready data-memory bus between the M stage and memory.
// master (M stage): bus_req, bus_we, bus_addr, bus_be, bus_wdata out; bus_ready, bus_rdata in.
// slave (memory): the mirror image.
interface m_stage_mem_ctrl_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W/8-1:0]   bus_be;
  logic [DATA_W-1:0]     bus_wdata;
  logic                  bus_ready;
  logic [DATA_W-1:0]     bus_rdata;
  modport master (output bus_req, bus_we, bus_addr, bus_be, bus_wdata, input bus_ready, bus_rdata);
  modport slave  (input bus_req, bus_we, bus_addr, bus_be, bus_wdata, output bus_ready, bus_rdata);
endinterface

// File: rtl/m_stage_mem_ctrl.sv
// m_stage_mem_ctrl: turns the load/store held in M into one bus transaction, stalling until done.
// in : clk, reset (sync, active-low), i_m_valid, i_m_op, i_m_addr, i_m_wdata, i_m_pc
// out: o_stall, o_ld_valid, o_ld_data, o_adel, o_ades, o_exc_pc
// bus: m_stage_mem_ctrl_if.master (request side of the data-memory bus)
module m_stage_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_m_valid,
  input  logic [3:0]        i_m_op,
  input  logic [ADDR_W-1:0] i_m_addr,
  input  logic [DATA_W-1:0] i_m_wdata,
  input  logic [ADDR_W-1:0] i_m_pc,
  output logic              o_stall,
  output logic              o_ld_valid,
  output logic [DATA_W-1:0] o_ld_data,
  output logic              o_adel,
  output logic              o_ades,
  output logic [ADDR_W-1:0] o_exc_pc,
  m_stage_mem_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam logic [3:0] OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3, OP_LB = 4'd4, OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;
  state_t      r_state, w_next;
  logic [1:0]  r_addr;
  logic [3:0]  r_op;
  logic        w_is_ld, w_is_st, w_aligned, w_req_ok, w_start, w_mis;
  logic [3:0]  w_be;
  logic [DATA_W-1:0] w_wdata, w_ext;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  always_comb begin
    w_is_ld   = i_m_op >= OP_LW && i_m_op <= OP_LBU;
    w_is_st   = i_m_op >= OP_SW && i_m_op <= OP_SB;
    w_aligned = (i_m_op == OP_LW || i_m_op == OP_SW) ? i_m_addr[1:0] == 2'b00 :
                (i_m_op == OP_LH || i_m_op == OP_LHU || i_m_op == OP_SH) ? !i_m_addr[0] : 1'b1;
    w_req_ok  = r_state == IDLE && i_m_valid && (w_is_ld || w_is_st);
    w_start   = w_req_ok && w_aligned;
    w_mis     = w_req_ok && !w_aligned;
    // Gated by reset so the pipeline is never held while the block is being reset.
    o_stall   = reset && (w_start || r_state == REQ);
    w_next    = r_state == IDLE ? (w_start ? REQ : IDLE) :
                r_state == REQ  ? (bus.bus_ready ? DONE : REQ) : IDLE;
    w_be      = i_m_op == OP_SW ? 4'b1111 :
                i_m_op == OP_SH ? (i_m_addr[1] ? 4'b1100 : 4'b0011) :
                i_m_op == OP_SB ? 4'b0001 << i_m_addr[1:0] : 4'b0000;
    w_wdata   = i_m_op == OP_SH ? {2{i_m_wdata[15:0]}} :
                i_m_op == OP_SB ? {4{i_m_wdata[7:0]}} : i_m_wdata;
    w_half    = r_addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    w_byte    = r_addr[0] ? w_half[15:8] : w_half[7:0];
    w_ext     = r_op == OP_LW  ? bus.bus_rdata :
                r_op == OP_LH  ? {{16{w_half[15]}}, w_half} :
                r_op == OP_LHU ? {16'h0, w_half} :
                r_op == OP_LB  ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_addr        <= '0;
      r_op          <= '0;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      o_ld_valid    <= 1'b0;
      o_ld_data     <= '0;
      o_adel        <= 1'b0;
      o_ades        <= 1'b0;
      o_exc_pc      <= '0;
    end else begin
      r_state    <= w_next;
      o_ld_valid <= 1'b0;
      o_adel     <= w_mis && w_is_ld;
      o_ades     <= w_mis && w_is_st;
      if (w_mis) o_exc_pc <= i_m_pc;
      if (w_start) begin
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= w_is_st;
        bus.bus_addr  <= {i_m_addr[ADDR_W-1:2], 2'b00};
        bus.bus_be    <= w_be;
        bus.bus_wdata <= w_wdata;
        r_addr        <= i_m_addr[1:0];
        r_op          <= i_m_op;
      end
      if (r_state == REQ && bus.bus_ready) begin
        bus.bus_req <= 1'b0;
        // Only memory ops are ever latched, so anything below sw is a load.
        if (r_op < OP_SW) begin
          o_ld_data  <= w_ext;
          o_ld_valid <= 1'b1;
        end
      end
    end
  end
endmodule
